arbitro_acumulador: RTL and testbench

- Sequences and shares one saturating accumulator datapath (10-bit operands in, 8-bit result out) between N_REQ requesters.
- Each requester asks for a burst of operands. The arbiter grants round-robin, clears the accumulator, streams the winner's operands through a valid/ready handshake, then returns the saturated sum tagged with the requester id.
- Sits between operand producers and the result consumer.

---
 rtl/arbitro_acumulador_pkg.sv | 18 +
 rtl/arbitro_acumulador_sat.sv | 44 ++++
 rtl/arbitro_acumulador.sv | 166 ++++++++++++++++
 tb/tb_arbitro_acumulador.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_acumulador_pkg.sv
// Shared constants for the round-robin accumulator arbiter: widths, saturation limit
// and the FSM state encoding.
package arbitro_acumulador_pkg;

    localparam int W_IN    = 10;
    localparam int W_RES   = 8;
    localparam int W_LEN   = 4;
    localparam int W_ACC   = W_IN + W_LEN;
    localparam int SAT_MAX = (1 << W_RES) - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/arbitro_acumulador_sat.sv
// Unsigned burst accumulator wide enough never to wrap; the sum is clamped to the
// result width only on the way out.
module acumulador_sat #(
    parameter int W_IN  = arbitro_acumulador_pkg::W_IN,
    parameter int W_RES = arbitro_acumulador_pkg::W_RES,
    parameter int W_LEN = arbitro_acumulador_pkg::W_LEN
) (
    input  logic             clk,
    input  logic             i_rs,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic [W_IN-1:0]  i_data,
    output logic [W_RES-1:0] o_res,
    output logic             o_ovf
);
    import arbitro_acumulador_pkg::*;

    localparam int ACC_W = W_IN + W_LEN;
    localparam logic [ACC_W-1:0] SAT_LIM = {{(ACC_W-W_RES){1'b0}}, {W_RES{1'b1}}};

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;

    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_en) begin
            acc_d = acc_q + ACC_W'(i_data);
        end
    end

    always_ff @(posedge clk or negedge i_rs) begin
        if (!i_rs) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_ovf = (acc_q > SAT_LIM);
    assign o_res = o_ovf ? SAT_LIM[W_RES-1:0] : acc_q[W_RES-1:0];

endmodule

// File: rtl/arbitro_acumulador.sv
// Round-robin arbiter that lends one saturating accumulator to N_REQ burst requesters
// and returns each burst's clamped sum tagged with the owner id.
module arbitro_acumulador #(
    parameter int  W_IN  = arbitro_acumulador_pkg::W_IN,
    parameter int  W_RES = arbitro_acumulador_pkg::W_RES,
    parameter int  N_REQ = 2,
    parameter int  W_LEN = arbitro_acumulador_pkg::W_LEN,
    localparam int W_ID  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   i_rs,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [N_REQ*W_LEN-1:0] i_len,
    input  logic [N_REQ*W_IN-1:0]  i_data,
    input  logic [N_REQ-1:0]       i_valid,
    output logic [N_REQ-1:0]       o_ready,
    output logic [N_REQ-1:0]       o_grant,
    output logic [W_RES-1:0]       o_res,
    output logic                   o_res_valid,
    output logic [W_ID-1:0]        o_res_id,
    output logic                   o_ovf
);
    import arbitro_acumulador_pkg::*;

    state_e           state_q, state_d;
    logic [W_ID-1:0]  gnt_q, gnt_d;
    logic [W_ID-1:0]  last_q, last_d;
    logic [W_LEN-1:0] cnt_q, cnt_d;
    logic [W_RES-1:0] res_q, res_d;
    logic [W_ID-1:0]  res_id_q, res_id_d;
    logic             ovf_q, ovf_d;

    logic             any_req;
    logic [W_ID-1:0]  winner;
    logic [W_ID-1:0]  rr_idx;
    logic [W_LEN-1:0] len_win;
    logic [W_IN-1:0]  data_g;
    logic             valid_g;
    logic [N_REQ-1:0] gnt_oh;
    logic             acc_clr, acc_en;
    logic [W_RES-1:0] acc_res;
    logic             acc_ovf;

    // Walk from the highest offset down so the requester right after last_q wins last.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        rr_idx  = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            rr_idx = W_ID'((int'(last_q) + i) % N_REQ);
            if (i_req[rr_idx]) begin
                any_req = 1'b1;
                winner  = rr_idx;
            end
        end
    end

    always_comb begin
        len_win = '0;
        data_g  = '0;
        valid_g = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == W_ID'(k)) begin
                len_win = i_len[k*W_LEN +: W_LEN];
            end
            if (gnt_q == W_ID'(k)) begin
                data_g  = i_data[k*W_IN +: W_IN];
                valid_g = i_valid[k];
            end
        end
    end

    assign gnt_oh = N_REQ'(1) << gnt_q;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        res_id_d    = res_id_q;
        ovf_d       = ovf_q;
        acc_clr     = 1'b0;
        acc_en      = 1'b0;
        o_grant     = '0;
        o_ready     = '0;
        o_res_valid = 1'b0;
        o_res       = res_q;
        o_res_id    = res_id_q;
        o_ovf       = ovf_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d   = winner;
                    cnt_d   = len_win;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                o_grant = gnt_oh;
                acc_clr = 1'b1;
                state_d = (cnt_q == '0) ? ST_DONE : ST_ACCUM;
            end
            ST_ACCUM: begin
                o_grant = gnt_oh;
                o_ready = gnt_oh;
                if (valid_g) begin
                    acc_en = 1'b1;
                    cnt_d  = cnt_q - W_LEN'(1);
                    if (cnt_q == W_LEN'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // Result is presented straight from the accumulator and captured for holding.
                o_grant     = gnt_oh;
                o_res_valid = 1'b1;
                o_res       = acc_res;
                o_res_id    = gnt_q;
                o_ovf       = acc_ovf;
                res_d       = acc_res;
                res_id_d    = gnt_q;
                ovf_d       = acc_ovf;
                last_d      = gnt_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge i_rs) begin
        if (!i_rs) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            last_q   <= W_ID'(N_REQ - 1);
            cnt_q    <= '0;
            res_q    <= '0;
            res_id_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
            res_id_q <= res_id_d;
            ovf_q    <= ovf_d;
        end
    end

    acumulador_sat #(
        .W_IN  (W_IN),
        .W_RES (W_RES),
        .W_LEN (W_LEN)
    ) u_acc (
        .clk    (clk),
        .i_rs   (i_rs),
        .i_clr  (acc_clr),
        .i_en   (acc_en),
        .i_data (data_g),
        .o_res  (acc_res),
        .o_ovf  (acc_ovf)
    );

endmodule

// File: tb/tb_arbitro_acumulador.sv
// Scoreboard bench for arbitro_acumulador: producers stream bursts, a monitor checks
// each result against sums computed when the burst was issued.
module tb_arbitro_acumulador;
    localparam int N  = 2;
    localparam int WI = 10;
    localparam int WL = 4;
    localparam int WR = 8;
    localparam int MAXR = (1 << WR) - 1;

    logic          clk = 1'b0;
    logic          i_rs;
    logic [N-1:0]  i_req, i_valid, o_ready, o_grant;
    logic [N*WL-1:0] i_len;
    logic [N*WI-1:0] i_data;
    logic [WR-1:0] o_res;
    logic          o_res_valid;
    logic [0:0]    o_res_id;
    logic          o_ovf;

    always #5 clk = ~clk;

    arbitro_acumulador dut (
        .clk         (clk),
        .i_rs        (i_rs),
        .i_req       (i_req),
        .i_len       (i_len),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_grant     (o_grant),
        .o_res       (o_res),
        .o_res_valid (o_res_valid),
        .o_res_id    (o_res_id),
        .o_ovf       (o_ovf)
    );

    typedef struct packed {
        int id; int len; int gap; bit rnd; bit lat;
        logic [15:0][WI-1:0] d;
    } burst_t;
    typedef struct packed { int id; int res; int ovf; int issue; int len; bit lat; } exp_t;

    burst_t pend[$];
    exp_t   sbq[$];
    int     order_q[$];
    int     errors = 0, checks = 0, cyc = 0;
    bit     busy[N], acc_seen[N], done_seen[N];
    burst_t cur[N];
    int     pos[N], gapc[N];
    int     hold_res = 0, hold_ovf = 0, hold_id = 0;
    int     m_idx;
    exp_t   m_e;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic add_burst(input int id, input int len, input int gap, input bit rnd,
                             input bit lat, input int maxv, input int d0 = -1,
                             input int d1 = -1, input int d2 = -1);
        burst_t b;
        b.id = id; b.len = len; b.gap = gap; b.rnd = rnd; b.lat = lat;
        for (int i = 0; i < 16; i++) b.d[i] = WI'($urandom_range(0, maxv));
        if (d0 >= 0) b.d[0] = WI'(d0);
        if (d1 >= 0) b.d[1] = WI'(d1);
        if (d2 >= 0) b.d[2] = WI'(d2);
        pend.push_back(b);
    endtask

    task automatic load_next(input int k);
        int s;
        exp_t e;
        for (int i = 0; i < pend.size(); i++) begin
            if (pend[i].id == k) begin
                cur[k] = pend[i];
                pend.delete(i);
                busy[k] = 1'b1; pos[k] = 0; gapc[k] = 0;
                s = 0;
                for (int j = 0; j < cur[k].len; j++) s += int'(cur[k].d[j]);
                e.id = k; e.res = (s > MAXR) ? MAXR : s; e.ovf = (s > MAXR) ? 1 : 0;
                e.issue = cyc; e.len = cur[k].len; e.lat = cur[k].lat;
                sbq.push_back(e);
                return;
            end
        end
    endtask

    // Producer side: account for accepted beats, retire finished bursts, drive inputs.
    task automatic refresh();
        for (int k = 0; k < N; k++) begin
            if (busy[k] && acc_seen[k]) begin
                pos[k]++;
                gapc[k] = cur[k].gap;
            end
            acc_seen[k] = 1'b0;
            if (done_seen[k]) begin busy[k] = 1'b0; done_seen[k] = 1'b0; end
            if (!busy[k]) load_next(k);
            i_req[k] = busy[k];
            i_len[k*WL +: WL] = busy[k] ? WL'(cur[k].len) : WL'($urandom);
            if (busy[k] && pos[k] < cur[k].len) i_data[k*WI +: WI] = cur[k].d[pos[k]];
            else i_data[k*WI +: WI] = WI'($urandom);
            if (!busy[k]) i_valid[k] = 1'($urandom_range(0, 1));
            else if (gapc[k] > 0) begin i_valid[k] = 1'b0; gapc[k]--; end
            else i_valid[k] = (pos[k] < cur[k].len) && (!cur[k].rnd || $urandom_range(0, 3) != 0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        refresh();
    endtask

    task automatic run_until_idle(input int budget);
        int n = 0;
        while ((pend.size() > 0 || sbq.size() > 0 || busy[0] || busy[1]) && n < budget) begin
            step();
            n++;
        end
        if (pend.size() > 0 || sbq.size() > 0 || busy[0] || busy[1]) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results still outstanding after %0d cycles", sbq.size(), n);
        end
    endtask

    always @(negedge clk) begin
        if (i_rs) begin
            for (int k = 0; k < N; k++) begin
                acc_seen[k] = o_ready[k] & i_valid[k];
                if (!busy[k]) check("ready_without_req", int'(o_ready[k]), 0);
                else if (pos[k] > 0 && pos[k] < cur[k].len) check("ready_mid_burst", int'(o_ready[k]), 1);
            end
            check("ready_outside_grant", int'(o_ready & ~o_grant), 0);
            if (o_res_valid) begin
                m_idx = -1;
                for (int i = 0; i < sbq.size(); i++)
                    if (m_idx < 0 && sbq[i].id == int'(o_res_id)) m_idx = i;
                check("result_expected", (m_idx >= 0) ? 1 : 0, 1);
                if (m_idx >= 0) begin
                    m_e = sbq[m_idx];
                    sbq.delete(m_idx);
                    check("res_value", int'(o_res), m_e.res);
                    check("res_ovf", int'(o_ovf), m_e.ovf);
                    if (m_e.lat) check("latency", cyc - m_e.issue, m_e.len + 2);
                    hold_res = m_e.res; hold_ovf = m_e.ovf; hold_id = m_e.id;
                end
                done_seen[o_res_id] = 1'b1;
                if (order_q.size() > 0) begin
                    check("grant_order", int'(o_res_id), order_q[0]);
                    void'(order_q.pop_front());
                end
            end else begin
                check("res_hold", int'(o_res), hold_res);
                check("ovf_hold", int'(o_ovf), hold_ovf);
                check("id_hold", int'(o_res_id), hold_id);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, int'(o_grant), 0);
        check({tag, "_ready"}, int'(o_ready), 0);
        check({tag, "_res"}, int'(o_res), 0);
        check({tag, "_res_valid"}, int'(o_res_valid), 0);
        check({tag, "_res_id"}, int'(o_res_id), 0);
        check({tag, "_ovf"}, int'(o_ovf), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < N; k++) begin busy[k] = 0; acc_seen[k] = 0; done_seen[k] = 0; pos[k] = 0; gapc[k] = 0; end
        i_rs = 1'b0; i_req = '1; i_len = '0; i_data = '0; i_valid = '1;

        // Reset held with both requests asserted, then requester 0 must win first.
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        i_rs = 1'b1;
        add_burst(0, 1, 0, 0, 0, 1023, 7);
        add_burst(1, 1, 0, 0, 0, 1023, 9);
        order_q.push_back(0); order_q.push_back(1);
        refresh();
        step();
        @(negedge clk);
        check("first_grant", int'(o_grant), 1);
        run_until_idle(100);

        // Single burst, continuous valid.
        add_burst(0, 3, 0, 0, 1, 1023, 4, 6, 10);
        run_until_idle(100);

        // Saturating burst with two idle cycles between beats.
        add_burst(1, 2, 2, 0, 0, 1023, 200, 100);
        run_until_idle(100);

        // Contention, both requesters continuously requesting.
        for (int r = 0; r < 2; r++) begin
            order_q.push_back(0); order_q.push_back(1);
            add_burst(0, 1, 0, 0, 0, 1023, 11 + r);
            add_burst(1, 1, 0, 0, 0, 1023, 22 + r);
        end
        run_until_idle(200);

        // Zero-length burst.
        add_burst(0, 0, 0, 0, 1, 1023);
        run_until_idle(100);

        // Asynchronous reset in the middle of a burst.
        add_burst(0, 5, 0, 0, 0, 1023);
        for (int n = 0; n < 50 && pos[0] < 2; n++) step();
        check("abort_progress", pos[0], 2);
        #2;
        i_rs = 1'b0;
        #1;
        check_all_zero("async_reset");
        for (int k = 0; k < N; k++) begin busy[k] = 0; acc_seen[k] = 0; done_seen[k] = 0; pos[k] = 0; gapc[k] = 0; end
        sbq.delete(); pend.delete(); order_q.delete();
        hold_res = 0; hold_ovf = 0; hold_id = 0;
        @(posedge clk); @(posedge clk); #1;
        i_rs = 1'b1;
        add_burst(0, 1, 0, 0, 1, 1023, 4);
        refresh();
        run_until_idle(100);

        // Randomized traffic: random owners, lengths, gaps and operand ranges.
        for (int b = 0; b < 40; b++)
            add_burst($urandom_range(0, 1), $urandom_range(0, 15), 0, 1, 0,
                      ($urandom_range(0, 1) == 1) ? 1023 : 30);
        run_until_idle(4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
